// File: rtl/dram_bank_sched_if.sv
// Request-queue and DDR command-bus signals of the DRAM bank scheduler.
// master = queue/controller side, slave = the scheduler itself.
interface dram_bank_sched_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [32:0] req_addr;
    logic        cmd_valid;
    logic [2:0]  cmd;
    logic [1:0]  cmd_bg;
    logic [1:0]  cmd_ba;
    logic [14:0] cmd_row;
    logic [7:0]  cmd_col;
    logic        done;
    logic [15:0] bank_open;

    modport master (
        output req_valid, req_op, req_addr,
        input  req_ready, cmd_valid, cmd, cmd_bg, cmd_ba, cmd_row, cmd_col,
        input  done, bank_open
    );

    modport slave (
        input  req_valid, req_op, req_addr,
        output req_ready, cmd_valid, cmd, cmd_bg, cmd_ba, cmd_row, cmd_col,
        output done, bank_open
    );
endinterface

// File: rtl/dram_bank_sched.sv
// In-order DRAM command sequencer: takes one request at a time, tracks the
// open row of all 16 banks and issues the minimal PRE/ACT/RD/WR sequence
// (open-page policy) while honouring tRP, tRCD, tRAS and CAS+burst latency.
module dram_bank_sched #(
    parameter int T_RP    = 24,
    parameter int T_RCD   = 24,
    parameter int T_RAS   = 52,
    parameter int T_CL    = 24,
    parameter int T_CWL   = 20,
    parameter int T_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    dram_bank_sched_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_PRE, S_TRP, S_ACT, S_TRCD, S_CAS, S_DATA
    } state_t;

    localparam logic [2:0] CMD_NOP = 3'd0;
    localparam logic [2:0] CMD_ACT = 3'd1;
    localparam logic [2:0] CMD_RD  = 3'd2;
    localparam logic [2:0] CMD_WR  = 3'd3;
    localparam logic [2:0] CMD_PRE = 3'd4;

    // Counter loads are two short of the spacing where a state entry and a
    // terminal-count cycle already account for two clocks of the gap.
    localparam logic [7:0] RP_LOAD  = 8'(T_RP - 2);
    localparam logic [7:0] RCD_LOAD = 8'(T_RCD - 2);
    localparam logic [7:0] RAS_LOAD = 8'(T_RAS - 1);
    localparam logic [7:0] RD_LOAD  = 8'(T_CL + T_BURST - 1);
    localparam logic [7:0] WR_LOAD  = 8'(T_CWL + T_BURST - 1);

    state_t      state;
    state_t      state_next;
    logic [7:0]  wcnt;
    logic [15:0] open_bits;
    logic [14:0] open_row [16];
    logic [7:0]  ras_cnt  [16];

    logic [1:0]  lat_op;
    logic [3:0]  lat_bank;
    logic [14:0] lat_row;
    logic [7:0]  lat_col;

    logic [2:0]  cmd_c;
    logic        done_c;
    logic        ready_c;
    logic        accept;

    assign accept = (state == S_IDLE) && bus.req_valid;

    // State register; reset abandons any in-flight request.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next-state decode plus the per-state command, ready and done outputs.
    always_comb begin
        state_next = state;
        cmd_c      = CMD_NOP;
        done_c     = 1'b0;
        ready_c    = 1'b0;
        case (state)
            S_IDLE: begin
                ready_c = 1'b1;
                if (bus.req_valid) state_next = S_CHECK;
            end
            S_CHECK: begin
                if (open_bits[lat_bank] && open_row[lat_bank] == lat_row)
                    state_next = S_CAS;
                else if (open_bits[lat_bank])
                    state_next = S_PRE;
                else
                    state_next = S_ACT;
            end
            S_PRE: begin
                if (ras_cnt[lat_bank] == 8'd0) begin
                    cmd_c      = CMD_PRE;
                    state_next = S_TRP;
                end
            end
            S_TRP: begin
                if (wcnt == 8'd0) state_next = S_ACT;
            end
            S_ACT: begin
                cmd_c      = CMD_ACT;
                state_next = S_TRCD;
            end
            S_TRCD: begin
                if (wcnt == 8'd0) state_next = S_CAS;
            end
            S_CAS: begin
                cmd_c      = (lat_op == 2'd1) ? CMD_WR : CMD_RD;
                state_next = S_DATA;
            end
            S_DATA: begin
                if (wcnt == 8'd0) begin
                    done_c     = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Wait counter: loaded by PRE/ACT/CAS, counts down in the waiting states.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wcnt <= 8'd0;
        end else begin
            case (state)
                S_PRE:  if (cmd_c == CMD_PRE) wcnt <= RP_LOAD;
                S_ACT:  wcnt <= RCD_LOAD;
                S_CAS:  wcnt <= (lat_op == 2'd1) ? WR_LOAD : RD_LOAD;
                S_TRP, S_TRCD, S_DATA: if (wcnt != 8'd0) wcnt <= wcnt - 8'd1;
                default: ;
            endcase
        end
    end

    // Request latch, captured only on the accept edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lat_op   <= 2'd0;
            lat_bank <= 4'd0;
            lat_row  <= 15'd0;
            lat_col  <= 8'd0;
        end else if (accept) begin
            lat_op   <= bus.req_op;
            lat_bank <= {bus.req_addr[7:6], bus.req_addr[9:8]};
            lat_row  <= bus.req_addr[32:18];
            lat_col  <= bus.req_addr[17:10];
        end
    end

    // Per-bank open row tracking; tRAS counters age every cycle in all states.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            open_bits <= 16'd0;
            for (int i = 0; i < 16; i++) begin
                open_row[i] <= 15'd0;
                ras_cnt[i]  <= 8'd0;
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (ras_cnt[i] != 8'd0) ras_cnt[i] <= ras_cnt[i] - 8'd1;
            end
            if (cmd_c == CMD_ACT) begin
                open_bits[lat_bank] <= 1'b1;
                open_row[lat_bank]  <= lat_row;
                ras_cnt[lat_bank]   <= RAS_LOAD;
            end
            if (cmd_c == CMD_PRE) open_bits[lat_bank] <= 1'b0;
        end
    end

    assign bus.req_ready = ready_c;
    assign bus.cmd_valid = (cmd_c != CMD_NOP);
    assign bus.cmd       = cmd_c;
    assign bus.done      = done_c;
    assign bus.bank_open = open_bits;
    assign bus.cmd_bg    = (state == S_IDLE) ? 2'd0  : lat_bank[3:2];
    assign bus.cmd_ba    = (state == S_IDLE) ? 2'd0  : lat_bank[1:0];
    assign bus.cmd_row   = (state == S_IDLE) ? 15'd0 : lat_row;
    assign bus.cmd_col   = (state == S_IDLE) ? 8'd0  : lat_col;

endmodule

// File: tb/tb_dram_bank_sched.sv
// Self-checking bench for dram_bank_sched: directed table, tRAS stall and
// reset-in-flight sequences, then random requests against a timeline model.
module tb_dram_bank_sched;

    localparam int T_RP    = 24;
    localparam int T_RCD   = 24;
    localparam int T_CL    = 24;
    localparam int T_CWL   = 20;
    localparam int T_BURST = 4;

    localparam logic [2:0] C_NOP = 3'd0;
    localparam logic [2:0] C_ACT = 3'd1;
    localparam logic [2:0] C_RD  = 3'd2;
    localparam logic [2:0] C_WR  = 3'd3;
    localparam logic [2:0] C_PRE = 3'd4;

    logic clk;
    logic rst_n;
    logic sel;
    logic drv_valid;
    logic [1:0] drv_op;
    logic [32:0] drv_addr;
    int cyc;
    int checks;
    int errors;

    dram_bank_sched_if bus_a ();
    dram_bank_sched_if bus_b ();

    dram_bank_sched dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    dram_bank_sched #(.T_RAS(100)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    assign bus_a.req_valid = drv_valid & ~sel;
    assign bus_b.req_valid = drv_valid & sel;
    assign bus_a.req_op    = drv_op;
    assign bus_b.req_op    = drv_op;
    assign bus_a.req_addr  = drv_addr;
    assign bus_b.req_addr  = drv_addr;

    logic        obs_ready, obs_cmd_valid, obs_done;
    logic [2:0]  obs_cmd;
    logic [1:0]  obs_bg, obs_ba;
    logic [14:0] obs_row;
    logic [7:0]  obs_col;
    logic [15:0] obs_open;

    assign obs_ready     = sel ? bus_b.req_ready : bus_a.req_ready;
    assign obs_cmd_valid = sel ? bus_b.cmd_valid : bus_a.cmd_valid;
    assign obs_done      = sel ? bus_b.done      : bus_a.done;
    assign obs_cmd       = sel ? bus_b.cmd       : bus_a.cmd;
    assign obs_bg        = sel ? bus_b.cmd_bg    : bus_a.cmd_bg;
    assign obs_ba        = sel ? bus_b.cmd_ba    : bus_a.cmd_ba;
    assign obs_row       = sel ? bus_b.cmd_row   : bus_a.cmd_row;
    assign obs_col       = sel ? bus_b.cmd_col   : bus_a.cmd_col;
    assign obs_open      = sel ? bus_b.bank_open : bus_a.bank_open;

    // Free-running clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: per-bank open flag, row and cycle of the last ACT.
    logic [15:0] m_open;
    int          m_row [16];
    int          m_act [16];

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  bg;
        logic [1:0]  ba;
        logic [14:0] row;
        logic [7:0]  col;
        int          pre_off;
        int          act_off;
        int          cas_off;
        int          done_off;
        logic [15:0] open_after;
    } vec_t;

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    task automatic model_clear();
        m_open = 16'd0;
        for (int i = 0; i < 16; i++) begin
            m_row[i] = -1;
            m_act[i] = -1000;
        end
    endtask

    task automatic do_reset();
        drv_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic check_idle(input string tag);
        check_output({tag, "_ready"}, 32'(obs_ready), 32'd1);
        check_output({tag, "_cmd"}, {28'd0, obs_cmd_valid, obs_cmd}, 32'd0);
        check_output({tag, "_done"}, 32'(obs_done), 32'd0);
        check_output({tag, "_fields"}, {5'd0, obs_bg, obs_ba, obs_row, obs_col}, 32'd0);
        check_output({tag, "_open"}, 32'(obs_open), 32'(m_open));
    endtask

    function automatic logic [15:0] open_at(int c, int e_pre, int e_act, int idx, logic [15:0] base);
        logic [15:0] v;
        v = base;
        if (e_pre >= 0)      v[idx] = (c <= e_pre || c > e_act) ? 1'b1 : 1'b0;
        else if (e_act >= 0) v[idx] = (c > e_act) ? 1'b1 : 1'b0;
        else                 v[idx] = 1'b1;
        return v;
    endfunction

    // Issue one request (starting at a negedge with the DUT idle) and check
    // every cycle against the model timeline until done, plus one cycle.
    task automatic apply_stimulus(input logic [1:0] op, input logic [1:0] bg, input logic [1:0] ba,
                                  input logic [14:0] row, input logic [7:0] col,
                                  output int pre_off, output int act_off,
                                  output int cas_off, output int done_off);
        int n, idx, ras, lat, e_pre, e_act, e_cas, e_done, waited, c;
        logic [2:0] e_cmd;
        logic [15:0] base;
        bit seen_done;
        idx = {bg, ba};
        drv_valid = 1'b1;
        drv_op = op;
        drv_addr = {row, col, ba, bg, 6'($urandom)};
        waited = 0;
        while (obs_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check_output("accept_ready", 32'(obs_ready), 32'd1);
        n = cyc;
        ras = sel ? 100 : 52;
        lat = (op == 2'd1) ? (T_CWL + T_BURST) : (T_CL + T_BURST);
        base = m_open;
        e_pre = -1;
        e_act = -1;
        if (m_open[idx] && m_row[idx] == int'(row)) begin
            e_cas = n + 2;
        end else begin
            if (m_open[idx]) begin
                e_pre = (n + 2 > m_act[idx] + ras) ? n + 2 : m_act[idx] + ras;
                e_act = e_pre + T_RP;
            end else begin
                e_act = n + 2;
            end
            e_cas = e_act + T_RCD;
        end
        e_done = e_cas + lat;

        @(negedge clk);
        drv_valid = 1'b0;
        drv_op = 2'($urandom);
        drv_addr = 33'({$urandom(), $urandom()});
        pre_off = -1;
        act_off = -1;
        cas_off = -1;
        done_off = -1;
        seen_done = 0;
        while (!seen_done && cyc <= e_done + 4) begin
            c = cyc;
            if (c == e_pre)      e_cmd = C_PRE;
            else if (c == e_act) e_cmd = C_ACT;
            else if (c == e_cas) e_cmd = (op == 2'd1) ? C_WR : C_RD;
            else                 e_cmd = C_NOP;
            check_output("cmd", 32'(obs_cmd), 32'(e_cmd));
            check_output("cmd_valid", 32'(obs_cmd_valid), 32'(e_cmd != C_NOP));
            check_output("done", 32'(obs_done), 32'(c == e_done));
            check_output("busy_ready", 32'(obs_ready), 32'd0);
            check_output("cmd_fields", {5'd0, obs_bg, obs_ba, obs_row, obs_col}, {5'd0, bg, ba, row, col});
            check_output("bank_open", 32'(obs_open), 32'(open_at(c, e_pre, e_act, idx, base)));
            if (obs_cmd == C_PRE && pre_off < 0) pre_off = c - n;
            if (obs_cmd == C_ACT && act_off < 0) act_off = c - n;
            if ((obs_cmd == C_RD || obs_cmd == C_WR) && cas_off < 0) cas_off = c - n;
            if (obs_done === 1'b1) begin
                seen_done = 1;
                done_off = c - n;
            end
            @(negedge clk);
        end
        if (!seen_done) check_output("done_timeout", 32'd0, 32'd1);
        check_output("ready_after_done", 32'(obs_ready), 32'd1);
        if (e_act >= 0) begin
            m_open[idx] = 1'b1;
            m_row[idx] = int'(row);
            m_act[idx] = e_act;
        end
    endtask

    vec_t tbl [7];

    initial begin
        int p, a, k, d, waited, busy_hits;
        logic [1:0] r_op, r_bg, r_ba;
        logic [14:0] r_row;
        bit seen;
        checks = 0;
        errors = 0;
        cyc = 0;
        sel = 1'b0;
        drv_valid = 1'b0;
        drv_op = 2'd0;
        drv_addr = 33'd0;
        rst_n = 1'b0;
        model_clear();

        tbl[0] = '{2'd0, 2'd1, 2'd2, 15'd5, 8'd3,  -1,  2, 26, 54, 16'h0040};
        tbl[1] = '{2'd2, 2'd1, 2'd2, 15'd5, 8'd8,  -1, -1,  2, 30, 16'h0040};
        tbl[2] = '{2'd3, 2'd1, 2'd2, 15'd9, 8'd1,   2, 26, 50, 78, 16'h0040};
        tbl[3] = '{2'd1, 2'd0, 2'd0, 15'd1, 8'd7,  -1,  2, 26, 50, 16'h0041};
        tbl[4] = '{2'd1, 2'd1, 2'd2, 15'd9, 8'd2,  -1, -1,  2, 26, 16'h0041};
        tbl[5] = '{2'd0, 2'd3, 2'd3, 15'd2, 8'd9,  -1,  2, 26, 54, 16'h8041};
        tbl[6] = '{2'd0, 2'd3, 2'd3, 15'd7, 8'd4,   2, 26, 50, 78, 16'h8041};

        // Reset state on both instances.
        do_reset();
        check_idle("reset_a");
        sel = 1'b1;
        check_idle("reset_b");
        sel = 1'b0;

        // Directed table, issued back to back.
        for (int i = 0; i < 7; i++) begin
            apply_stimulus(tbl[i].op, tbl[i].bg, tbl[i].ba, tbl[i].row, tbl[i].col, p, a, k, d);
            check_output($sformatf("tbl%0d_pre", i), 32'(p), 32'(tbl[i].pre_off));
            check_output($sformatf("tbl%0d_act", i), 32'(a), 32'(tbl[i].act_off));
            check_output($sformatf("tbl%0d_cas", i), 32'(k), 32'(tbl[i].cas_off));
            check_output($sformatf("tbl%0d_done", i), 32'(d), 32'(tbl[i].done_off));
            check_output($sformatf("tbl%0d_open", i), 32'(obs_open), 32'(tbl[i].open_after));
        end

        // tRAS stall on the T_RAS=100 instance, then a write to a closed bank.
        sel = 1'b1;
        do_reset();
        apply_stimulus(2'd0, 2'd1, 2'd2, 15'd5, 8'd3, p, a, k, d);
        check_output("ras_first_done", 32'(d), 32'd54);
        apply_stimulus(2'd0, 2'd1, 2'd2, 15'd9, 8'd3, p, a, k, d);
        check_output("ras_pre", 32'(p), 32'd47);
        check_output("ras_act", 32'(a), 32'd71);
        check_output("ras_cas", 32'(k), 32'd95);
        apply_stimulus(2'd1, 2'd2, 2'd1, 15'd3, 8'd5, p, a, k, d);
        check_output("wr_cas", 32'(k), 32'd26);
        check_output("wr_cas_to_done", 32'(d - k), 32'd24);

        // Reset while waiting out tRP, then fresh closed-bank requests.
        sel = 1'b0;
        do_reset();
        apply_stimulus(2'd0, 2'd0, 2'd0, 15'd1, 8'd0, p, a, k, d);
        drv_valid = 1'b1;
        drv_op = 2'd0;
        drv_addr = {15'd2, 8'd0, 2'd0, 2'd0, 6'd0};
        @(negedge clk);
        drv_valid = 1'b0;
        seen = 0;
        waited = 0;
        while (!seen && waited < 60) begin
            if (obs_cmd === C_PRE) seen = 1;
            @(negedge clk);
            waited++;
        end
        check_output("mid_pre_seen", 32'(seen), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        check_idle("mid_reset");
        busy_hits = 0;
        for (int i = 0; i < 40; i++) begin
            if (obs_done !== 1'b0 || obs_cmd_valid !== 1'b0 || obs_ready !== 1'b1) busy_hits++;
            @(negedge clk);
        end
        check_output("post_reset_quiet", 32'(busy_hits), 32'd0);
        apply_stimulus(2'd0, 2'd0, 2'd0, 15'd1, 8'd6, p, a, k, d);
        check_output("fresh_pre", 32'(p), 32'hFFFF_FFFF);
        check_output("fresh_act", 32'(a), 32'd2);
        apply_stimulus(2'd0, 2'd3, 2'd3, 15'd4, 8'd6, p, a, k, d);
        check_output("indep_pre", 32'(p), 32'hFFFF_FFFF);
        check_output("indep_open", 32'(obs_open), 32'h0000_8001);

        // Random requests with idle gaps, checked against the model.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                check_idle("gap");
                @(negedge clk);
            end
            r_op  = 2'($urandom_range(0, 3));
            r_bg  = 2'($urandom_range(0, 3));
            r_ba  = 2'($urandom_range(0, 1));
            r_row = 15'($urandom_range(0, 2));
            apply_stimulus(r_op, r_bg, r_ba, r_row, 8'($urandom), p, a, k, d);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop in case a bounded wait was mis-sized.
    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
